// File: rtl/frame_buf_sched.sv
// Double-buffer scheduler between camera capture (SDRAM write port) and VGA scan-out (read port).
// A completed frame is handed to the reader only at a VGA start-of-frame, so no frame is shown torn.
module frame_buf_sched #(
  parameter int                ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] BASE0       = 23'h000000,
  parameter logic [ADDR_W-1:0] BASE1       = 23'h100000,
  parameter int                FRAME_WORDS = 153600,
  parameter int                LOAD_LEN    = 2,
  parameter int                CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_fval,
  input  logic              i_wr_word,
  input  logic              i_rd_sof,
  output logic              o_wr_load,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W-1:0] o_wr_max_addr,
  output logic              o_wr_en,
  output logic              o_rd_load,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_rd_max_addr,
  output logic              o_rd_en,
  output logic              o_wr_buf,
  output logic              o_rd_buf,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam int WC_W = $clog2(FRAME_WORDS + 2);
  localparam int LC_W = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
  localparam logic [WC_W-1:0]   WC_FULL = WC_W'(FRAME_WORDS);
  localparam logic [WC_W-1:0]   WC_SAT  = WC_W'(FRAME_WORDS + 1);
  localparam logic [LC_W-1:0]   LC_LAST = LC_W'(LOAD_LEN - 1);
  localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_CAPT = 2'd2,
    W_FULL = 2'd3
  } wstate_t;

  typedef enum logic [1:0] {
    R_WAIT = 2'd0,
    R_SWAP = 2'd1,
    R_LOAD = 2'd2
  } rstate_t;

  wstate_t          wstate, wstate_nx;
  rstate_t          rstate, rstate_nx;
  logic             fval_q;
  logic             fval_rise, fval_fall;
  logic             wr_buf, rd_buf, full, rd_en;
  logic [WC_W-1:0]  word_cnt, word_eff;
  logic [LC_W-1:0]  wl_cnt, rl_cnt;
  logic [CNT_W-1:0] drop_cnt, err_cnt;
  logic             err_inc, drop_inc, set_full, swap;

  // fval_q resets high so a frame already in progress at reset is skipped until fval drops.
  assign fval_rise = i_wr_fval & ~fval_q;
  assign fval_fall = ~i_wr_fval & fval_q;
  assign swap      = (rstate == R_SWAP);

  // Word count including the word presented this cycle, saturating one past a full frame.
  always_comb begin
    word_eff = word_cnt;
    if (i_wr_word && (word_cnt != WC_SAT)) begin
      word_eff = word_cnt + {{(WC_W-1){1'b0}}, 1'b1};
    end else begin
      word_eff = word_cnt;
    end
  end

  // Writer next-state and event decode.
  always_comb begin
    wstate_nx = wstate;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
    set_full  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (fval_rise) wstate_nx = W_LOAD;
        else           wstate_nx = W_IDLE;
      end
      W_LOAD: begin
        if (fval_fall) begin
          err_inc   = 1'b1;
          wstate_nx = W_IDLE;
        end else if (wl_cnt == LC_LAST) begin
          wstate_nx = W_CAPT;
        end else begin
          wstate_nx = W_LOAD;
        end
      end
      W_CAPT: begin
        if (fval_fall) begin
          if (word_eff == WC_FULL) begin
            set_full  = 1'b1;
            wstate_nx = W_FULL;
          end else begin
            err_inc   = 1'b1;
            wstate_nx = W_IDLE;
          end
        end else begin
          wstate_nx = W_CAPT;
        end
      end
      W_FULL: begin
        drop_inc = fval_rise;
        if (swap) wstate_nx = W_IDLE;
        else      wstate_nx = W_FULL;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  // Reader next-state: a full buffer is taken at sof, otherwise the shown frame is re-loaded.
  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_WAIT: begin
        if (i_rd_sof) begin
          if (full)       rstate_nx = R_SWAP;
          else if (rd_en) rstate_nx = R_LOAD;
          else            rstate_nx = R_WAIT;
        end else begin
          rstate_nx = R_WAIT;
        end
      end
      R_SWAP: rstate_nx = R_LOAD;
      R_LOAD: begin
        if (rl_cnt == LC_LAST) rstate_nx = R_WAIT;
        else                   rstate_nx = R_LOAD;
      end
      default: rstate_nx = R_WAIT;
    endcase
  end

  // State registers, counters and buffer ownership.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wstate   <= W_IDLE;
      rstate   <= R_WAIT;
      fval_q   <= 1'b1;
      wr_buf   <= 1'b0;
      rd_buf   <= 1'b1;
      full     <= 1'b0;
      rd_en    <= 1'b0;
      word_cnt <= '0;
      wl_cnt   <= '0;
      rl_cnt   <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      wstate <= wstate_nx;
      rstate <= rstate_nx;
      fval_q <= i_wr_fval;
      word_cnt <= (wstate == W_CAPT) ? word_eff : '0;
      wl_cnt   <= (wstate == W_LOAD) ? wl_cnt + {{(LC_W-1){1'b0}}, 1'b1} : '0;
      rl_cnt   <= (rstate == R_LOAD) ? rl_cnt + {{(LC_W-1){1'b0}}, 1'b1} : '0;
      if (swap) begin
        wr_buf <= rd_buf;
        rd_buf <= wr_buf;
        full   <= 1'b0;
        rd_en  <= 1'b1;
      end else if (set_full) begin
        full <= 1'b1;
      end
      if (err_inc && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (drop_inc && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_wr_load     = (wstate == W_LOAD);
  assign o_wr_en       = (wstate == W_CAPT);
  assign o_rd_load     = (rstate == R_LOAD);
  assign o_rd_en       = rd_en;
  assign o_wr_buf      = wr_buf;
  assign o_rd_buf      = rd_buf;
  assign o_drop_cnt    = drop_cnt;
  assign o_err_cnt     = err_cnt;
  assign o_wr_addr     = wr_buf ? BASE1 : BASE0;
  assign o_rd_addr     = rd_buf ? BASE1 : BASE0;
  assign o_wr_max_addr = o_wr_addr + FW_A;
  assign o_rd_max_addr = o_rd_addr + FW_A;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Scoreboard bench for frame_buf_sched: expected buffer state is queued per load pulse,
// a negedge monitor compares it when the DUT raises o_wr_load / o_rd_load.
module tb_frame_buf_sched;

  localparam int AW = 23;
  localparam int FW = 40;
  localparam int LL = 2;
  localparam int CW = 8;
  localparam logic [22:0] B0 = 23'h000000;
  localparam logic [22:0] B1 = 23'h100000;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic fval = 1'b0;
  logic word = 1'b0;
  logic sof  = 1'b0;
  logic watch_wren = 1'b0;

  logic          o_wr_load, o_wr_en, o_rd_load, o_rd_en, o_wr_buf, o_rd_buf;
  logic [AW-1:0] o_wr_addr, o_wr_max_addr, o_rd_addr, o_rd_max_addr;
  logic [CW-1:0] o_drop_cnt, o_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          wr_buf;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_max;
  } wexp_t;

  typedef struct packed {
    logic          rd_buf;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          wr_buf;
    logic [AW-1:0] wr_addr;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];

  frame_buf_sched #(
    .ADDR_W(AW), .BASE0(B0), .BASE1(B1), .FRAME_WORDS(FW), .LOAD_LEN(LL), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_fval(fval), .i_wr_word(word), .i_rd_sof(sof),
    .o_wr_load(o_wr_load), .o_wr_addr(o_wr_addr), .o_wr_max_addr(o_wr_max_addr),
    .o_wr_en(o_wr_en), .o_rd_load(o_rd_load), .o_rd_addr(o_rd_addr),
    .o_rd_max_addr(o_rd_max_addr), .o_rd_en(o_rd_en), .o_wr_buf(o_wr_buf),
    .o_rd_buf(o_rd_buf), .o_drop_cnt(o_drop_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on each load rising edge, and measures load pulse length.
  logic prev_wl = 1'b0, prev_rl = 1'b0;
  int   wl_len = 0, rl_len = 0, wren_in_full = 0;
  always @(negedge clk) begin
    if (o_wr_load === 1'b1 && prev_wl !== 1'b1) begin
      if (wq.size() == 0) begin
        chk("wr_load_unexpected", 32'd1, 32'd0);
      end else begin
        chk("wr_load_buf", {31'd0, o_wr_buf}, {31'd0, wq[0].wr_buf});
        chk("wr_load_addr", {9'd0, o_wr_addr}, {9'd0, wq[0].wr_addr});
        chk("wr_load_max", {9'd0, o_wr_max_addr}, {9'd0, wq[0].wr_max});
        void'(wq.pop_front());
      end
    end
    if (o_wr_load === 1'b1) wl_len <= wl_len + 1;
    else if (prev_wl === 1'b1) begin
      chk("wr_load_len", wl_len, LL);
      wl_len <= 0;
    end
    if (o_rd_load === 1'b1 && prev_rl !== 1'b1) begin
      if (rq.size() == 0) begin
        chk("rd_load_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_load_rd_buf", {31'd0, o_rd_buf}, {31'd0, rq[0].rd_buf});
        chk("rd_load_rd_addr", {9'd0, o_rd_addr}, {9'd0, rq[0].rd_addr});
        chk("rd_load_rd_max", {9'd0, o_rd_max_addr}, {9'd0, rq[0].rd_addr + 23'd40});
        chk("rd_load_rd_en", {31'd0, o_rd_en}, {31'd0, rq[0].rd_en});
        chk("rd_load_wr_buf", {31'd0, o_wr_buf}, {31'd0, rq[0].wr_buf});
        chk("rd_load_wr_addr", {9'd0, o_wr_addr}, {9'd0, rq[0].wr_addr});
        void'(rq.pop_front());
      end
    end
    if (o_rd_load === 1'b1) rl_len <= rl_len + 1;
    else if (prev_rl === 1'b1) begin
      chk("rd_load_len", rl_len, LL);
      rl_len <= 0;
    end
    if (watch_wren && o_wr_en === 1'b1) wren_in_full <= wren_in_full + 1;
    prev_wl <= o_wr_load;
    prev_rl <= o_rd_load;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise fval, wait for capture enable, push n words, drop fval (optionally with sof).
  task automatic send_frame(input int n, input logic sof_at_fall);
    logic found;
    found = 1'b0;
    fval = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (o_wr_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("wr_en_start", {31'd0, found}, 32'd1);
    for (int k = 0; k < n; k++) begin
      word = 1'b1;
      tick(1);
    end
    word = 1'b0;
    tick(1);
    fval = 1'b0;
    sof  = sof_at_fall;
    tick(1);
    sof = 1'b0;
    tick(3);
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick(1);
    sof = 1'b0;
    tick(LL + 4);
  endtask

  task automatic fval_pulse();
    fval = 1'b1;
    tick(3);
    fval = 1'b0;
    tick(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_buf"}, {31'd0, o_wr_buf}, 32'd0);
    chk({tag, "_rd_buf"}, {31'd0, o_rd_buf}, 32'd1);
    chk({tag, "_rd_en"}, {31'd0, o_rd_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, o_wr_en}, 32'd0);
    chk({tag, "_loads"}, {30'd0, o_wr_load, o_rd_load}, 32'd0);
    chk({tag, "_wr_addr"}, {9'd0, o_wr_addr}, 32'd0);
    chk({tag, "_wr_max"}, {9'd0, o_wr_max_addr}, 32'd40);
    chk({tag, "_rd_addr"}, {9'd0, o_rd_addr}, 32'h100000);
    chk({tag, "_cnts"}, {16'd0, o_drop_cnt, o_err_cnt}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    check_reset_outputs("reset");

    // Short frame then long frame: errors, no swap, display stays off.
    wq.push_back('{1'b0, B0, B0 + 23'd40});
    send_frame(FW - 1, 1'b0);
    pulse_sof();
    chk("short_err_cnt", {24'd0, o_err_cnt}, 32'd1);
    chk("short_rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("short_rd_buf", {31'd0, o_rd_buf}, 32'd1);
    wq.push_back('{1'b0, B0, B0 + 23'd40});
    send_frame(FW + 1, 1'b0);
    chk("long_err_cnt", {24'd0, o_err_cnt}, 32'd2);

    // Good frame then sof: first swap enables the display.
    wq.push_back('{1'b0, B0, B0 + 23'd40});
    send_frame(FW, 1'b0);
    rq.push_back('{1'b0, B0, 1'b1, 1'b1, B1});
    pulse_sof();
    chk("swap1_rd_en", {31'd0, o_rd_en}, 32'd1);

    // Complete frame then three more fval pulses: all dropped, capture stays off.
    wq.push_back('{1'b1, B1, B1 + 23'd40});
    send_frame(FW, 1'b0);
    watch_wren = 1'b1;
    fval_pulse();
    fval_pulse();
    fval_pulse();
    watch_wren = 1'b0;
    tick(1);
    chk("drop_cnt", {24'd0, o_drop_cnt}, 32'd3);
    chk("drop_wr_en_cycles", wren_in_full, 32'd0);
    chk("drop_wr_buf", {31'd0, o_wr_buf}, 32'd1);
    rq.push_back('{1'b1, B1, 1'b1, 1'b0, B0});
    pulse_sof();

    // Completion coincides with sof: current frame re-shown, swap on the next sof.
    wq.push_back('{1'b0, B0, B0 + 23'd40});
    rq.push_back('{1'b1, B1, 1'b1, 1'b0, B0});
    send_frame(FW, 1'b1);
    chk("coincide_no_swap", {31'd0, o_rd_buf}, 32'd1);
    rq.push_back('{1'b0, B0, 1'b1, 1'b1, B1});
    pulse_sof();

    // Reset in the middle of a capture, then a normal frame.
    wq.push_back('{1'b1, B1, B1 + 23'd40});
    fval = 1'b1;
    tick(LL + 2);
    chk("pre_rst_wr_en", {31'd0, o_wr_en}, 32'd1);
    word = 1'b1;
    tick(20);
    rst  = 1'b1;
    word = 1'b0;
    fval = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b0;
    tick(2);
    wq.push_back('{1'b0, B0, B0 + 23'd40});
    send_frame(FW, 1'b0);
    rq.push_back('{1'b0, B0, 1'b1, 1'b1, B1});
    pulse_sof();
    chk("post_rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);

    tick(3);
    chk("wq_empty", wq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
